pkt_bank_buffer: RTL and testbench

Parametrised multi-bank packet buffer. It is the successor to the two-bank ping-pong FIFO between the CMOS capture path and the SPI/ESP32 readout. Pixel words qualified by frame/line valid are written into `NUM_BANKS` banks of `PKT_SIZE` words. Each full bank raises an interrupt and is drained in order by a word-level read handshake. The block adds packet-length reporting, overflow counting and optional end-of-frame flush.

---
 rtl/pkt_bank_buffer.sv | 95 +++++++++
 tb/tb_pkt_bank_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pkt_bank_buffer.sv
// pkt_bank_buffer: multi-bank packet buffer between pixel capture and a word-level reader.
// Define PKT_BANK_FRAME_FLUSH_EN to close a partial bank on the falling edge of frame_valid.
module pkt_bank_buffer #(
    parameter int DATA_W    = 8,
    parameter int PKT_SIZE  = 11552,
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = 14,
    parameter int BANK_W    = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              pix_en,
    input  logic              frame_valid,
    input  logic              line_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              pkt_ready,
    output logic              intr_out,
    output logic [ADDR_W:0]   pkt_len,
    output logic [BANK_W-1:0] rd_bank,
    output logic              full,
    output logic [15:0]       ovf_cnt
);
    logic [DATA_W-1:0] mem [NUM_BANKS][PKT_SIZE];
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [BANK_W:0]   filled;
    logic [ADDR_W:0]   head_len;
    logic              qual, wr, last, close, acc, rel;

    assign qual      = pix_en & frame_valid & line_valid;
    assign wr        = qual & ~full;
    assign last      = wr & (wr_addr == ADDR_W'(PKT_SIZE - 1));
    assign acc       = rd_en & pkt_ready;
    assign rel       = acc & ({1'b0, rd_addr} == head_len - 1'b1);
    assign full      = filled == (BANK_W+1)'(NUM_BANKS);
    assign pkt_ready = filled != '0;
    // Length reads as zero when nothing is pending so all outputs are clear out of reset.
    assign pkt_len   = pkt_ready ? head_len : '0;

`ifdef PKT_BANK_FRAME_FLUSH_EN
    logic [ADDR_W:0] len [NUM_BANKS];
    logic [ADDR_W:0] close_len;
    logic            fv_q;
    assign close     = last | (fv_q & ~frame_valid & (wr_addr != '0) & ~full);
    assign close_len = last ? (ADDR_W+1)'(PKT_SIZE) : {1'b0, wr_addr};
    assign head_len  = len[rd_bank];
    always_ff @(posedge sys_clk) begin
        fv_q <= sys_rst ? 1'b0 : frame_valid;
        if (close) len[wr_bank] <= close_len;
    end
`else
    assign close    = last;
    assign head_len = (ADDR_W+1)'(PKT_SIZE);
`endif

    always_ff @(posedge sys_clk) begin
        if (wr) mem[wr_bank][wr_addr] <= pix_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_bank  <= '0;
            wr_addr  <= '0;
            rd_bank  <= '0;
            rd_addr  <= '0;
            filled   <= '0;
            ovf_cnt  <= '0;
            intr_out <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            intr_out <= close;
            rd_valid <= acc;
            if (acc) rd_data <= mem[rd_bank][rd_addr];
            if (close) begin
                wr_addr <= '0;
                wr_bank <= wr_bank + 1'b1;
            end else if (wr) begin
                wr_addr <= wr_addr + 1'b1;
            end
            if (rel) begin
                rd_addr <= '0;
                rd_bank <= rd_bank + 1'b1;
            end else if (acc) begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (close & ~rel) filled <= filled + 1'b1;
            else if (rel & ~close) filled <= filled - 1'b1;
            if (qual & full & (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pkt_bank_buffer.sv
// tb_pkt_bank_buffer: directed tests for pkt_bank_buffer with 2 banks of 16 bytes.
module tb_pkt_bank_buffer;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       pix_en = 1'b0, frame_valid = 1'b0, line_valid = 1'b0, rd_en = 1'b0;
    logic [7:0] pix_data = '0;
    logic [7:0] rd_data;
    logic       rd_valid, pkt_ready, intr_out, full;
    logic [4:0] pkt_len;
    logic       rd_bank;
    logic [15:0] ovf_cnt;
    int n_chk = 0, n_fail = 0;

    pkt_bank_buffer #(.DATA_W(8), .PKT_SIZE(16), .NUM_BANKS(2), .ADDR_W(4), .BANK_W(1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pix_en(pix_en), .frame_valid(frame_valid),
        .line_valid(line_valid), .pix_data(pix_data), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .pkt_ready(pkt_ready), .intr_out(intr_out), .pkt_len(pkt_len),
        .rd_bank(rd_bank), .full(full), .ovf_cnt(ovf_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1; pix_en = 1'b0; rd_en = 1'b0; frame_valid = 1'b0; line_valid = 1'b0;
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] d);
        pix_en = 1'b1; frame_valid = 1'b1; line_valid = 1'b1; pix_data = d;
        tick();
        pix_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if ({pkt_ready, intr_out, full, rd_valid, rd_bank} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=00000", {pkt_ready, intr_out, full, rd_valid, rd_bank}); end
        n_chk++; if (ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_ovf got=%0d exp=0", ovf_cnt); end
        n_chk++; if (pkt_len !== 5'd0) begin n_fail++; $display("FAIL reset_len got=%0d exp=0", pkt_len); end
        n_chk++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rd_data); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            write_word(8'(i));
            if (i == 14) begin
                n_chk++; if (intr_out !== 1'b0 || pkt_ready !== 1'b0) begin n_fail++; $display("FAIL fill_early got=%b%b exp=00", intr_out, pkt_ready); end
            end
        end
        n_chk++; if (intr_out !== 1'b1) begin n_fail++; $display("FAIL fill_intr got=%b exp=1", intr_out); end
        n_chk++; if (pkt_ready !== 1'b1 || pkt_len !== 5'd16 || rd_bank !== 1'b0) begin n_fail++; $display("FAIL fill_head got=%b/%0d/%0d exp=1/16/0", pkt_ready, pkt_len, rd_bank); end
        tick();
        n_chk++; if (intr_out !== 1'b0) begin n_fail++; $display("FAIL fill_intr_pulse got=%b exp=0", intr_out); end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            n_chk++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'(i)); end
            if (i == 14) begin
                n_chk++; if (pkt_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready got=%b exp=1", pkt_ready); end
            end
        end
        n_chk++; if (pkt_ready !== 1'b0) begin n_fail++; $display("FAIL drain_done got=%b exp=0", pkt_ready); end
        tick();
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_idle got=%b exp=0", rd_valid); end
        rd_en = 1'b0;
    endtask

    task automatic test_overflow();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            write_word(8'(i));
            if (intr_out) pulses++;
        end
        n_chk++; if (pulses !== 2) begin n_fail++; $display("FAIL ovf_pulses got=%0d exp=2", pulses); end
        n_chk++; if (full !== 1'b1 || ovf_cnt !== 16'd8) begin n_fail++; $display("FAIL ovf_state got=%b/%0d exp=1/8", full, ovf_cnt); end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            n_chk++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, rd_data, 8'(i)); end
        end
        rd_en = 1'b0;
        n_chk++; if (full !== 1'b0 || rd_bank !== 1'b1) begin n_fail++; $display("FAIL ovf_free got=%b/%0d exp=0/1", full, rd_bank); end
        write_word(8'h99);
        n_chk++; if (dut.wr_bank !== 1'b0 || dut.wr_addr !== 4'd1 || ovf_cnt !== 16'd8) begin n_fail++; $display("FAIL ovf_next got=%0d/%0d/%0d exp=0/1/8", dut.wr_bank, dut.wr_addr, ovf_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) write_word(8'hA0 + 8'(i));
        for (int i = 0; i < 15; i++) write_word(8'hB0 + 8'(i));
        for (int i = 0; i < 15; i++) begin
            rd_en = 1'b1;
            tick();
        end
        n_chk++; if (rd_data !== 8'hAE) begin n_fail++; $display("FAIL sim_pre got=%h exp=ae", rd_data); end
        pix_en = 1'b1; pix_data = 8'hBF;
        tick();
        pix_en = 1'b0; rd_en = 1'b0;
        n_chk++; if (dut.filled !== 2'd1 || rd_bank !== 1'b1 || intr_out !== 1'b1) begin n_fail++; $display("FAIL sim_close got=%0d/%0d/%b exp=1/1/1", dut.filled, rd_bank, intr_out); end
        n_chk++; if (rd_valid !== 1'b1 || rd_data !== 8'hAF || pkt_ready !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL sim_read got=%b/%h/%b/%b exp=1/af/1/0", rd_valid, rd_data, pkt_ready, full); end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            n_chk++; if (rd_data !== 8'hB0 + 8'(i)) begin n_fail++; $display("FAIL sim_b1_%0d got=%h exp=%h", i, rd_data, 8'hB0 + 8'(i)); end
        end
        rd_en = 1'b0;
        n_chk++; if (pkt_ready !== 1'b0) begin n_fail++; $display("FAIL sim_empty got=%b exp=0", pkt_ready); end
    endtask

    task automatic test_gating();
        do_reset();
        pix_en = 1'b1; frame_valid = 1'b0; line_valid = 1'b1;
        tick();
        frame_valid = 1'b1; line_valid = 1'b0;
        tick();
        pix_en = 1'b0; frame_valid = 1'b0;
        tick();
        n_chk++; if (dut.wr_addr !== 4'd0 || ovf_cnt !== 16'd0 || intr_out !== 1'b0) begin n_fail++; $display("FAIL gate got=%0d/%0d/%b exp=0/0/0", dut.wr_addr, ovf_cnt, intr_out); end
        write_word(8'h11);
        n_chk++; if (dut.wr_addr !== 4'd1) begin n_fail++; $display("FAIL gate_write got=%0d exp=1", dut.wr_addr); end
    endtask

    task automatic test_frame_flush();
        do_reset();
        for (int i = 0; i < 5; i++) write_word(8'h30 + 8'(i));
        frame_valid = 1'b0; line_valid = 1'b0;
        tick();
`ifdef PKT_BANK_FRAME_FLUSH_EN
        n_chk++; if (intr_out !== 1'b1 || pkt_ready !== 1'b1 || pkt_len !== 5'd5) begin n_fail++; $display("FAIL flush_close got=%b/%b/%0d exp=1/1/5", intr_out, pkt_ready, pkt_len); end
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            tick();
            n_chk++; if (rd_data !== 8'h30 + 8'(i)) begin n_fail++; $display("FAIL flush_rd_%0d got=%h exp=%h", i, rd_data, 8'h30 + 8'(i)); end
        end
        n_chk++; if (pkt_ready !== 1'b0 || rd_bank !== 1'b1) begin n_fail++; $display("FAIL flush_release got=%b/%0d exp=0/1", pkt_ready, rd_bank); end
        tick();
        rd_en = 1'b0;
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_extra got=%b exp=0", rd_valid); end
`else
        n_chk++; if (intr_out !== 1'b0 || pkt_ready !== 1'b0) begin n_fail++; $display("FAIL noflush_close got=%b/%b exp=0/0", intr_out, pkt_ready); end
        tick();
        n_chk++; if (dut.wr_addr !== 4'd5) begin n_fail++; $display("FAIL noflush_addr got=%0d exp=5", dut.wr_addr); end
        write_word(8'h40);
        n_chk++; if (dut.wr_addr !== 4'd6 || dut.wr_bank !== 1'b0) begin n_fail++; $display("FAIL noflush_next got=%0d/%0d exp=6/0", dut.wr_addr, dut.wr_bank); end
`endif
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        for (int i = 0; i < 16; i++) write_word(8'hC0 + 8'(i));
        write_word(8'hEE);
        for (int i = 0; i < 7; i++) begin
            rd_en = 1'b1;
            tick();
        end
        n_chk++; if (rd_data !== 8'hC6) begin n_fail++; $display("FAIL mid_pre got=%h exp=c6", rd_data); end
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0; rd_en = 1'b0;
        n_chk++; if ({pkt_ready, rd_valid, full, intr_out, rd_bank} !== 5'b0 || ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_rst got=%b/%0d exp=00000/0", {pkt_ready, rd_valid, full, intr_out, rd_bank}, ovf_cnt); end
        n_chk++; if (dut.wr_bank !== 1'b0 || dut.wr_addr !== 4'd0) begin n_fail++; $display("FAIL mid_ptr got=%0d/%0d exp=0/0", dut.wr_bank, dut.wr_addr); end
        for (int i = 0; i < 16; i++) write_word(8'h50 + 8'(i));
        n_chk++; if (intr_out !== 1'b1 || rd_bank !== 1'b0) begin n_fail++; $display("FAIL mid_refill got=%b/%0d exp=1/0", intr_out, rd_bank); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_chk++; if (rd_data !== 8'h50) begin n_fail++; $display("FAIL mid_first got=%h exp=50", rd_data); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_back_to_back();
        test_gating();
        test_frame_flush();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
